// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and width helper for the prescaled counter
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // ceil(log2(value)) but never below 1, so a prescale of 1 still gets a 1-bit register
    function automatic int safe_clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << bits) < 64'(value)) begin
                bits = bits + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every PRESCALE enabled cycles
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = 125_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PS_WIDTH = safe_clog2(PRESCALE);
    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [PS_WIDTH-1:0] PS_ONE  = PS_WIDTH'(1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("tick_gen: PRESCALE must be at least 1");
        end
    endgenerate

    logic [PS_WIDTH-1:0] ps_q;
    logic [PS_WIDTH-1:0] ps_d;

    // strobe in the last enabled cycle of each prescale period
    always_comb begin
        tick = en && (ps_q == PS_LAST);
    end

    // clear wins over counting; hold while disabled
    always_comb begin
        ps_d = ps_q;
        if (clr) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = tick ? '0 : (ps_q + PS_ONE);
        end
    end

    // prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// rtl/prescaled_counter.sv - prescaled up/down counter with wrap/saturate, load and terminal pulse
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 125_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] modulo,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("prescaled_counter: WIDTH must be at least 1");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("prescaled_counter: PRESCALE must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             tc_q;
    logic             tc_d;

    // a load restarts the prescale period so the next step is a full period away
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // next count: load beats step; dir/sat/modulo only matter on the step cycle
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        if (load) begin
            out_d = (load_value > modulo) ? modulo : load_value;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (out_q < modulo) begin
                    out_d = out_q + CNT_ONE;
                end else begin
                    // at the top, or stranded above a lowered modulo
                    tc_d = 1'b1;
                    if ((out_q > modulo) || (sat == MODE_WRAP)) begin
                        out_d = '0;
                    end
                end
            end else begin
                if (out_q > modulo) begin
                    // stranded above a lowered modulo: pull back into range quietly
                    out_d = modulo;
                end else if (out_q == '0) begin
                    tc_d = 1'b1;
                    if (sat == MODE_WRAP) begin
                        out_d = modulo;
                    end
                end else begin
                    out_d = out_q - CNT_ONE;
                end
            end
        end
    end

    // count and terminal-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// tb/tb_prescaled_counter.sv - scoreboard bench for prescaled_counter with WIDTH=4, PRESCALE=3
module tb_prescaled_counter;

    localparam int W = 4;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         sat;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] modulo;
    logic [W-1:0] out;
    logic         tick;
    logic         tc;

    int checks   = 0;
    int failures = 0;
    int ev_idx   = 0;

    typedef struct packed {
        logic [W-1:0] out;
        logic         tc;
    } exp_t;

    exp_t sb[$];
    logic pend = 1'b0;

    always #5 clk = ~clk;

    prescaled_counter #(
        .WIDTH    (W),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .sat        (sat),
        .load       (load),
        .load_value (load_value),
        .modulo     (modulo),
        .out        (out),
        .tick       (tick),
        .tc         (tc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] o, input logic t);
        exp_t e;
        e.out = o;
        e.tc  = t;
        sb.push_back(e);
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 40);
        if (!tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=none required=tick within 40 cycles");
        end
    endtask

    task automatic tick_gap(input string name, input int exp_gap);
        int n;
        wait_tick(n);
        check(name, n, exp_gap);
    endtask

    // monitor: every load or tick edge produces one expected out/tc pair
    always @(negedge clk) begin
        if (pend) begin : pop_blk
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=out %0d tc %0d required=no event", out, tc);
            end else begin
                e = sb.pop_front();
                check($sformatf("sb_out[%0d]", ev_idx), out, e.out);
                check($sformatf("sb_tc[%0d]", ev_idx), tc, e.tc);
            end
            ev_idx++;
        end
        pend = !rst && (tick || load);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; dir = 1'b1; sat = 1'b0;
        load = 1'b0; load_value = '0; modulo = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out", out, 0);
        check("reset_tc", tc, 0);
        check("reset_tick", tick, 0);

        // 1: up/wrap, modulo 5
        step_edge();
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
        push(4'd0, 1'b1);
        for (int i = 0; i < 6; i++) tick_gap("s1_gap", 3);
        step_edge();
        en = 1'b0;
        @(negedge clk);
        check("s1_tc_hi", tc, 1);
        check("s1_out_wrapped", out, 0);
        @(negedge clk);
        check("s1_tc_lo", tc, 0);

        // 2: saturate up, hold at 5 with pulses
        step_edge();
        sat = 1'b1;
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
        for (int i = 0; i < 3; i++) push(4'd5, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick_gap("s2_gap", 3);
        step_edge();
        en = 1'b0;

        // 3: down/wrap from load 2, then down/saturate from load 1
        sat = 1'b0; dir = 1'b0; load = 1'b1; load_value = 4'd2;
        push(4'd2, 1'b0);
        step_edge();
        load = 1'b0;
        push(4'd1, 1'b0); push(4'd0, 1'b0); push(4'd5, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick_gap("s3_gap", 3);
        step_edge();
        en = 1'b0; sat = 1'b1; load = 1'b1; load_value = 4'd1;
        push(4'd1, 1'b0);
        step_edge();
        load = 1'b0;
        push(4'd0, 1'b0); push(4'd0, 1'b1); push(4'd0, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick_gap("s3s_gap", 3);
        step_edge();
        en = 1'b0;

        // 4: load clamp, then load coinciding with tick
        sat = 1'b0; dir = 1'b1; modulo = 4'd9; load = 1'b1; load_value = 4'd12;
        push(4'd9, 1'b0);
        step_edge();
        load = 1'b0;
        @(negedge clk);
        check("s4_clamp", out, 9);
        step_edge();
        en = 1'b1;
        step_edge();
        step_edge();
        load = 1'b1; load_value = 4'd4;
        push(4'd4, 1'b0);
        @(negedge clk);
        check("s4_tick_with_load", tick, 1);
        step_edge();
        load = 1'b0;
        push(4'd5, 1'b0);
        tick_gap("s4_gap_after_load", 3);
        step_edge();
        en = 1'b0;

        // 5a: enable dropped for 4 cycles mid-prescale
        push(4'd6, 1'b0); push(4'd7, 1'b0);
        step_edge();
        en = 1'b1;
        step_edge();
        en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("s5_hold_out", out, 5);
            check("s5_hold_tick", tick, 0);
            step_edge();
        end
        en = 1'b1;
        wait_tick(n);
        check("s5_gated_delay", 1 + 4 + n, 7);
        tick_gap("s5_gap", 3);
        step_edge();
        en = 1'b0;

        // 5b: modulo 0, every step is terminal in all modes
        load = 1'b1; load_value = 4'd0; modulo = 4'd0;
        push(4'd0, 1'b0);
        step_edge();
        load = 1'b0;
        push(4'd0, 1'b1); push(4'd0, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 2; i++) tick_gap("s5b_gap", 3);
        step_edge();
        en = 1'b0; dir = 1'b0; sat = 1'b1;
        push(4'd0, 1'b1); push(4'd0, 1'b1);
        step_edge();
        en = 1'b1;
        for (int i = 0; i < 2; i++) tick_gap("s5b_gap_dn", 3);
        step_edge();
        en = 1'b0;

        // 5c: modulo lowered below the count
        dir = 1'b1; sat = 1'b0; modulo = 4'd9; load = 1'b1; load_value = 4'd7;
        push(4'd7, 1'b0);
        step_edge();
        load = 1'b0; modulo = 4'd3;
        push(4'd0, 1'b1);
        en = 1'b1;
        tick_gap("s5c_up_gap", 3);
        step_edge();
        en = 1'b0; modulo = 4'd9; load = 1'b1; load_value = 4'd7;
        push(4'd7, 1'b0);
        step_edge();
        load = 1'b0; modulo = 4'd3; dir = 1'b0;
        push(4'd3, 1'b0);
        en = 1'b1;
        tick_gap("s5c_dn_gap", 3);
        step_edge();
        en = 1'b0;

        // 6: reset with out=4, ps=1
        dir = 1'b1; modulo = 4'd9; load = 1'b1; load_value = 4'd4;
        push(4'd4, 1'b0);
        step_edge();
        load = 1'b0; en = 1'b1;
        step_edge();
        rst = 1'b1;
        step_edge();
        rst = 1'b0;
        push(4'd1, 1'b0);
        @(negedge clk);
        check("s6_rst_out", out, 0);
        check("s6_rst_tc", tc, 0);
        check("s6_rst_tick", tick, 0);
        wait_tick(n);
        check("s6_first_tick", 1 + n, 3);
        step_edge();
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_out", out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

Parametrised, prescaled up/down counter that replaces the fixed 4-bit free-running counter feeding the LED driver. Adds a clock prescaler, a programmable terminal value, direction control, wrap/saturate modes, synchronous load and a terminal-count pulse. Sits between the board clock domain (`clk`, 125 MHz) and display/driver logic, which consumes `out` and `tc`.

## Interface

Parameters:
- `WIDTH`, default 4: counter width in bits; must be ≥ 1.
- `PRESCALE`, default 125_000_000: enabled clock cycles per count step; must be ≥ 1, where 1 means step every enabled cycle.
- `PS_WIDTH`, default `$clog2(PRESCALE)` (minimum 1): prescaler register width; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `en`, in, 1: when 0, prescaler and counter hold; load still works.
- `dir`, in, 1: 1 counts up, 0 counts down.
- `sat`, in, 1: 1 selects saturate mode, 0 selects wrap mode.
- `load`, in, 1: synchronous load request.
- `load_value`, in, `WIDTH`: value applied on `load`.
- `modulo`, in, `WIDTH`: terminal (maximum) count value; the count range is 0..`modulo`.
- `out`, out, `WIDTH`: registered count.
- `tick`, out, 1: combinational step strobe, equal to `en` AND (prescaler == `PRESCALE`-1).
- `tc`, out, 1: registered one-cycle terminal-count pulse.

## Operation

- Prescaler `ps`:
  - When `en`=1, counts 0..`PRESCALE`-1, then wraps to 0.
  - When `en`=0, holds its value.
  - Cleared on `rst` or `load`.
- Priority, highest first: `rst`, then `load`, then step (`tick`), then hold.
- `rst`: `out`=0, `ps`=0, `tc`=0.
- `load`: `out` takes `load_value`, or `modulo` if `load_value` > `modulo`. `tc`=0. Any coincident tick is discarded.
- Step, up (`dir`=1):
  - `out` < `modulo`: `out`+1.
  - `out` == `modulo`: wrap mode gives 0; saturate mode holds. `tc`=1 in both modes.
  - `out` > `modulo` (after `modulo` was lowered): 0, with `tc`=1.
- Step, down (`dir`=0):
  - `out` > 0 and ≤ `modulo`: `out`-1.
  - `out` == 0: wrap mode gives `modulo`; saturate mode holds at 0. `tc`=1 in both modes.
  - `out` > `modulo`: clamp to `modulo`, with `tc`=0.
- `modulo`=0: every step is a terminal event. `out` stays 0 and `tc` pulses on every step.
- `tc` is 0 on every cycle without a terminal event. In saturate mode it re-pulses on each step attempted while pinned at the boundary.
- `dir`, `sat` and `modulo` are sampled only on the step cycle. Changing them mid-prescale has no other effect.

## Timing

- Reset values: `out`=0, `tc`=0, `ps`=0; `tick` therefore reads 0 unless `PRESCALE`=1 and `en`=1.
- Reset takes effect at the first rising edge with `rst`=1, including mid-prescale and mid-load.
- `tick` is high in the cycle where `ps`==`PRESCALE`-1 and `en`=1. `out` and `tc` update at the end of that cycle, so there is 1-cycle latency from `tick` to the new `out`.
- Step period with `en` held high: exactly `PRESCALE` cycles. The first step after reset or load occurs `PRESCALE` cycles later.
- `load` is visible on `out` the cycle after it is asserted.
- Deasserting `en` for N cycles delays the next step by exactly N cycles.

## Structure

- Shared package `counter_pkg`:
  - Constants `DIR_DOWN`=0, `DIR_UP`=1, `MODE_WRAP`=0, `MODE_SAT`=1.
  - A function computing the safe `$clog2` with minimum 1.
- Sub-module `tick_gen`: parameter `PRESCALE`; ports `clk`, `rst`, `en`, `clr`, `tick`. Holds the prescaler.
- `prescaled_counter` instantiates `tick_gen`, connecting `load` to `clr`, and contains the next-count logic and `tc` register.
- Elaboration-time assertions check `WIDTH` ≥ 1 and `PRESCALE` ≥ 1.

## Test plan

All scenarios use `WIDTH`=4 and `PRESCALE`=3.

1. Reset, then `en`=1, `dir`=1, `sat`=0, `modulo`=5 → `tick` on cycles 3, 6, 9…; `out` 0→1→…→5→0; `tc` high for exactly the cycle when `out` becomes 0.
2. Saturate up: `sat`=1, `modulo`=5, count to 5 → `out` holds 5 on later ticks; `tc` pulses on each of those ticks.
3. Down/wrap from load: `load`=1 with `load_value`=2, then `dir`=0 → `out` 2→1→0→5 with `tc` at the 0→5 step. Down/saturate with `sat`=1 → `out` holds at 0 with `tc` pulses.
4. Load clamp and priority:
   - `load_value`=12 with `modulo`=9 → `out`=9 next cycle.
   - `load` asserted in a `tick` cycle → `out`=`load_value`, no step.
   - The next `tick` comes 3 cycles after the load.
5. Enable gating and boundaries:
   - Drop `en` for 4 cycles mid-prescale → next step delayed by 4 cycles, `out` unchanged meanwhile.
   - `modulo`=0 → `out` stays 0 and `tc` pulses on every tick.
   - `modulo` lowered from 9 to 3 while `out`=7: an up step gives 0 with `tc`=1; a down step gives 3 with `tc`=0.
6. Reset mid-operation: assert `rst` when `out`=4 and `ps`=1 → next cycle `out`=0, `tc`=0; first `tick` 3 cycles after `rst` falls.
